// File: rtl/core_id_stage.sv
// Instruction decode stage: decodes RV32/64 base opcodes, selects operands with
// writeback bypass, detects load-use hazards and registers everything for EX.
module core_id_stage #(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       inst_in,
  input  logic [ADDR_W-1:0] inst_addr_in,
  output logic [REG_AW-1:0] read_reg1_addr_out,
  output logic [REG_AW-1:0] read_reg2_addr_out,
  input  logic [XLEN-1:0]   read_reg1_data_in,
  input  logic [XLEN-1:0]   read_reg2_data_in,
  input  logic              wb_we_in,
  input  logic [REG_AW-1:0] wb_addr_in,
  input  logic [XLEN-1:0]   wb_data_in,
  input  logic              flush_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       inst_out,
  output logic [ADDR_W-1:0] inst_addr_out,
  output logic              reg_we_out,
  output logic [REG_AW-1:0] reg_write_addr_out,
  output logic [XLEN-1:0]   reg1_data_out,
  output logic [XLEN-1:0]   reg2_data_out,
  output logic [XLEN-1:0]   imm_out,
  output logic              is_load_out,
  output logic              illegal_out
);

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [31:0] NOP_INST  = 32'h0000_0013;

  function automatic logic [XLEN-1:0] pick_operand(
    input logic [REG_AW-1:0] rs,
    input logic [XLEN-1:0]   rf_data,
    input logic              wb_we,
    input logic [REG_AW-1:0] wb_addr,
    input logic [XLEN-1:0]   wb_data
  );
    if (rs == {REG_AW{1'b0}}) begin
      return {XLEN{1'b0}};
    end else if (wb_we && (wb_addr == rs)) begin
      return wb_data;
    end else begin
      return rf_data;
    end
  endfunction

  logic [6:0]        opcode;
  logic [REG_AW-1:0] rs1, rs2, rd;
  logic              rs1_used, rs2_used, we_dec, load_dec, illegal_dec;
  logic signed [31:0] imm32;
  logic [XLEN-1:0]   imm_ext;
  logic              hazard, accept;

  logic              valid_q, valid_d;
  logic [31:0]       inst_q, inst_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              we_q, we_d;
  logic [REG_AW-1:0] rd_q, rd_d;
  logic [XLEN-1:0]   r1_q, r1_d, r2_q, r2_d, imm_q, imm_d;
  logic              load_q, load_d, ill_q, ill_d;
  logic [REG_AW-1:0] rs1_q, rs1_d, rs2_q, rs2_d;

  assign opcode             = inst_in[6:0];
  assign rs1                = REG_AW'(inst_in[19:15]);
  assign rs2                = REG_AW'(inst_in[24:20]);
  assign rd                 = REG_AW'(inst_in[11:7]);
  assign read_reg1_addr_out = rs1;
  assign read_reg2_addr_out = rs2;
  // Sign-extending cast: U-type immediates extend from bit 31 on 64-bit cores too.
  assign imm_ext            = XLEN'(imm32);

  // Opcode decode: operand usage, writeback/load/illegal flags and immediate format.
  always_comb begin
    rs1_used    = 1'b0;
    rs2_used    = 1'b0;
    we_dec      = 1'b0;
    load_dec    = 1'b0;
    illegal_dec = 1'b0;
    imm32       = 32'sd0;
    case (opcode)
      OPC_LUI, OPC_AUIPC: begin
        we_dec = 1'b1;
        imm32  = {inst_in[31:12], 12'b0};
      end
      OPC_JAL: begin
        we_dec = 1'b1;
        imm32  = {{11{inst_in[31]}}, inst_in[31], inst_in[19:12], inst_in[20], inst_in[30:21], 1'b0};
      end
      OPC_JALR, OPC_OPIMM: begin
        we_dec   = 1'b1;
        rs1_used = 1'b1;
        imm32    = {{20{inst_in[31]}}, inst_in[31:20]};
      end
      OPC_LOAD: begin
        we_dec   = 1'b1;
        rs1_used = 1'b1;
        load_dec = 1'b1;
        imm32    = {{20{inst_in[31]}}, inst_in[31:20]};
      end
      OPC_BRANCH: begin
        rs1_used = 1'b1;
        rs2_used = 1'b1;
        imm32    = {{19{inst_in[31]}}, inst_in[31], inst_in[7], inst_in[30:25], inst_in[11:8], 1'b0};
      end
      OPC_STORE: begin
        rs1_used = 1'b1;
        rs2_used = 1'b1;
        imm32    = {{20{inst_in[31]}}, inst_in[31:25], inst_in[11:7]};
      end
      OPC_OP: begin
        we_dec   = 1'b1;
        rs1_used = 1'b1;
        rs2_used = 1'b1;
      end
      default: begin
        illegal_dec = 1'b1;
      end
    endcase
  end

  assign hazard   = valid_q && load_q && (rd_q != {REG_AW{1'b0}}) &&
                    ((rs1_used && (rd_q == rs1)) || (rs2_used && (rd_q == rs2)));
  assign in_ready = !rst && !flush_in && !hazard && (!valid_q || out_ready);
  assign accept   = in_valid && in_ready;

  // Next-state: flush beats accept, accept beats drain, holding applies writeback bypass.
  always_comb begin
    valid_d = valid_q;
    inst_d  = inst_q;
    addr_d  = addr_q;
    we_d    = we_q;
    rd_d    = rd_q;
    r1_d    = r1_q;
    r2_d    = r2_q;
    imm_d   = imm_q;
    load_d  = load_q;
    ill_d   = ill_q;
    rs1_d   = rs1_q;
    rs2_d   = rs2_q;
    if (flush_in) begin
      valid_d = 1'b0;
    end else if (accept) begin
      valid_d = 1'b1;
      inst_d  = inst_in;
      addr_d  = inst_addr_in;
      we_d    = we_dec && (rd != {REG_AW{1'b0}});
      rd_d    = rd;
      r1_d    = pick_operand(rs1, read_reg1_data_in, wb_we_in, wb_addr_in, wb_data_in);
      r2_d    = pick_operand(rs2, read_reg2_data_in, wb_we_in, wb_addr_in, wb_data_in);
      imm_d   = imm_ext;
      load_d  = load_dec;
      ill_d   = illegal_dec;
      rs1_d   = rs1;
      rs2_d   = rs2;
    end else if (valid_q && out_ready) begin
      valid_d = 1'b0;
    end else if (valid_q) begin
      r1_d = pick_operand(rs1_q, r1_q, wb_we_in, wb_addr_in, wb_data_in);
      r2_d = pick_operand(rs2_q, r2_q, wb_we_in, wb_addr_in, wb_data_in);
      // pick_operand zeroes rs==0; a held zero register already carries 0.
    end else begin
      valid_d = 1'b0;
    end
  end

  // Output pipeline registers with asynchronous reset to a NOP bubble.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      inst_q  <= NOP_INST;
      addr_q  <= {ADDR_W{1'b0}};
      we_q    <= 1'b0;
      rd_q    <= {REG_AW{1'b0}};
      r1_q    <= {XLEN{1'b0}};
      r2_q    <= {XLEN{1'b0}};
      imm_q   <= {XLEN{1'b0}};
      load_q  <= 1'b0;
      ill_q   <= 1'b0;
      rs1_q   <= {REG_AW{1'b0}};
      rs2_q   <= {REG_AW{1'b0}};
    end else begin
      valid_q <= valid_d;
      inst_q  <= inst_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      rd_q    <= rd_d;
      r1_q    <= r1_d;
      r2_q    <= r2_d;
      imm_q   <= imm_d;
      load_q  <= load_d;
      ill_q   <= ill_d;
      rs1_q   <= rs1_d;
      rs2_q   <= rs2_d;
    end
  end

  assign out_valid          = valid_q;
  assign inst_out           = inst_q;
  assign inst_addr_out      = addr_q;
  assign reg_we_out         = we_q;
  assign reg_write_addr_out = rd_q;
  assign reg1_data_out      = r1_q;
  assign reg2_data_out      = r2_q;
  assign imm_out            = imm_q;
  assign is_load_out        = load_q;
  assign illegal_out        = ill_q;

endmodule
